// File: rtl/arm_mem_pkg.sv
// Shared types for the core-side memory port arbiter.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } arb_state_e;

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_e;

  localparam int unsigned StarveMaxDefault = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one unified memory port,
// one outstanding transaction at a time, with a bounded fetch-starvation count.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        proto_err
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            proto_err_q, proto_err_d;
  logic            starve_hit;
  logic            complete;

  assign starve_hit = (starve_cnt_q == CntMax);

  // Next-state, grant and completion routing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    starve_cnt_d = starve_cnt_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    proto_err_d  = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    m_req        = 1'b0;
    complete     = 1'b0;

    unique case (state_q)
      StIdle: begin
        proto_err_d = m_rvalid;
        if (!halt && if_req && (!d_req || starve_hit)) begin
          if_gnt       = 1'b1;
          owner_d      = OwnFetch;
          addr_d       = if_addr;
          we_d         = 1'b0;
          wdata_d      = 32'h0;
          starve_cnt_d = '0;
          state_d      = StReq;
        end else if (!halt && d_req) begin
          d_gnt   = 1'b1;
          owner_d = OwnData;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (if_req && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
          state_d = StReq;
        end
      end
      StReq: begin
        m_req = 1'b1;
        if (m_ack) begin
          complete = m_rvalid;
          state_d  = m_rvalid ? StIdle : StWait;
        end else begin
          // A response before the request is accepted cannot belong to it.
          proto_err_d = m_rvalid;
        end
      end
      StWait: begin
        if (m_rvalid) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      if (owner_q == OwnFetch) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = m_rdata;
      end else begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = m_rdata;
      end
    end

    // Combinational handshakes are held low while reset is asserted.
    if (rst) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      m_req  = 1'b0;
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      starve_cnt_q <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign m_addr    = addr_q;
  assign m_we      = we_q;
  assign m_wdata   = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level requester/memory
// model with a response scoreboard checked by an independent monitor.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst, halt;
  logic        if_req, d_req, d_we, m_ack, m_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, proto_err;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .proto_err(proto_err)
  );

  typedef struct {
    int          due;
    bit          is_data;
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  // Stimulus knobs.
  int p_if, p_d, p_halt, ack_lo, ack_hi, rv_lo, rv_hi;
  bit rd_fix_en;
  logic [31:0] rd_fix;

  // Requester state: a pending request is held until the model grants it.
  bit          if_pend, d_pend, dwe;
  logic [31:0] ia, da, dwd;

  // Transaction model: 0 = free, 1 = waiting for accept, 2 = accepted.
  int          phase;
  int          ack_wait, rv_wait, starve;
  bit          cur_data, cur_we;
  logic [31:0] cur_addr, cur_wdata;
  bit          exp_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit stray);
    bit exp_if, exp_d, exp_mreq;
    @(negedge clk);
    cyc++;
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1; ia = $urandom & 32'hFFFF_FFFC;
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend = 1; da = $urandom; dwe = 1'($urandom_range(1)); dwd = $urandom;
    end
    if_req = if_pend; if_addr = ia;
    d_req = d_pend; d_addr = da; d_we = dwe; d_wdata = dwd;
    halt = ($urandom_range(99) < p_halt);
    m_ack = 0; m_rvalid = 0;
    m_rdata = rd_fix_en ? rd_fix : $urandom;
    if (!rst) begin
      if (phase == 1) begin
        m_ack = (ack_wait == 0);
        m_rvalid = m_ack && (rv_wait == 0);
      end else if (phase == 2) begin
        m_rvalid = (rv_wait == 0);
      end
    end
    if (stray) m_rvalid = 1;
    #1;
    exp_if = 0; exp_d = 0; exp_mreq = 0;
    if (!rst) begin
      exp_mreq = (phase == 1);
      if (phase == 0 && !halt) begin
        if (if_pend && (!d_pend || starve == SMAX)) exp_if = 1;
        else if (d_pend) exp_d = 1;
      end
    end
    chk("if_gnt", if_gnt, exp_if);
    chk("d_gnt", d_gnt, exp_d);
    chk("m_req", m_req, exp_mreq);
    if (exp_mreq) begin
      chk("m_addr", m_addr, cur_addr);
      chk("m_we", m_we, cur_we);
      chk("m_wdata", m_wdata, cur_wdata);
    end
    chk("proto_err", proto_err, exp_perr);
    // Advance the model past the coming rising edge.
    exp_perr = 0;
    if (rst) begin
      phase = 0; starve = 0;
    end else begin
      if (phase == 0 || (phase == 1 && !m_ack)) exp_perr = m_rvalid;
      case (phase)
        0: if (exp_if || exp_d) begin
          cur_data  = exp_d;
          cur_addr  = exp_d ? da : ia;
          cur_we    = exp_d ? dwe : 1'b0;
          cur_wdata = exp_d ? dwd : 32'h0;
          if (exp_if) begin
            starve = 0; if_pend = 0;
          end else begin
            if (if_pend) starve = (starve < SMAX) ? starve + 1 : SMAX;
            d_pend = 0;
          end
          ack_wait = $urandom_range(ack_hi, ack_lo);
          rv_wait  = $urandom_range(rv_hi, rv_lo);
          phase = 1;
        end
        1: if (m_ack) begin
          if (m_rvalid) begin
            rsp_q.push_back('{due: cyc + 1, is_data: cur_data, data: m_rdata});
            phase = 0;
          end else begin
            rv_wait--; phase = 2;
          end
        end else begin
          ack_wait--;
        end
        2: if (m_rvalid) begin
          rsp_q.push_back('{due: cyc + 1, is_data: cur_data, data: m_rdata});
          phase = 0;
        end else begin
          rv_wait--;
        end
        default: phase = 0;
      endcase
    end
  endtask

  // Response monitor: pops the scoreboard when a completion is due.
  logic [31:0] last_if = 32'h0, last_d = 32'h0;
  always @(negedge clk) begin
    bit   e_if, e_d;
    rsp_t e;
    #2;
    if (mon_en) begin
      e_if = 0; e_d = 0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e = rsp_q.pop_front();
        if (e.is_data) begin e_d = 1; last_d = e.data; end
        else begin e_if = 1; last_if = e.data; end
      end
      chk("if_rvalid", if_rvalid, e_if);
      chk("d_rvalid", d_rvalid, e_d);
      chk("if_rdata", if_rdata, last_if);
      chk("d_rdata", d_rdata, last_d);
    end
    if (rst) begin last_if = 32'h0; last_d = 32'h0; end
  end

  task automatic run_until_wait(input string name);
    int n = 0;
    while (phase != 2 && n < 40) begin step(0); n++; end
    chk(name, 32'(phase == 2), 32'd1);
  endtask

  initial begin
    rst = 1; halt = 0; if_req = 0; d_req = 0; d_we = 0; m_ack = 0; m_rvalid = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    if_pend = 0; d_pend = 0; dwe = 0; ia = 0; da = 0; dwd = 0;
    phase = 0; starve = 0; exp_perr = 0; ack_wait = 0; rv_wait = 0;
    cur_data = 0; cur_we = 0; cur_addr = 0; cur_wdata = 0;
    p_if = 0; p_d = 0; p_halt = 0; ack_lo = 0; ack_hi = 0; rv_lo = 0; rv_hi = 0;
    rd_fix_en = 0; rd_fix = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_we", m_we, 0);
    rst = 0;
    mon_en = 1;

    // Single fetch against a zero-latency memory.
    if_pend = 1; ia = 32'h100; rd_fix_en = 1; rd_fix = 32'hE3A01005;
    repeat (4) step(0);
    rd_fix_en = 0;

    // Simultaneous fetch and store: data first, then fetch.
    if_pend = 1; ia = 32'h104;
    d_pend = 1; da = 32'h200; dwe = 1; dwd = 32'hDEADBEEF;
    repeat (6) step(0);

    // Both ports saturated: four data grants per fetch grant.
    p_if = 100; p_d = 100;
    repeat (40) step(0);

    // Slow memory: accept after 3 cycles, response 5 cycles later.
    p_if = 30; p_d = 30; ack_lo = 3; ack_hi = 3; rv_lo = 5; rv_hi = 5;
    repeat (60) step(0);

    // Halt while a load is outstanding.
    p_if = 0; p_d = 100; ack_lo = 1; ack_hi = 1; rv_lo = 4; rv_hi = 4;
    run_until_wait("halt_reach_wait");
    p_halt = 100; p_if = 100;
    repeat (12) step(0);
    p_halt = 0;

    // Reset with a load outstanding, then a late memory response.
    p_if = 0; p_d = 100;
    repeat (12) step(0);
    run_until_wait("rst_reach_wait");
    p_d = 0; if_pend = 0; d_pend = 0;
    rst = 1; step(0); rst = 0;
    step(1);
    repeat (3) step(0);

    // Mixed random traffic with random halts and latencies.
    p_if = 40; p_d = 40; p_halt = 10; ack_lo = 0; ack_hi = 3; rv_lo = 0; rv_hi = 5;
    repeat (1500) step(0);
    p_if = 0; p_d = 0; p_halt = 0;
    repeat (20) step(0);
    chk("scoreboard_empty", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
